// File: rtl/ul_pow_pkg.sv
// Shared constants, FSM encoding and pipeline sideband layout for the
// 60 MHz uplink per-antenna power measurement block.
package ul_pow_pkg;

    localparam int unsigned XNUM_DEF = 8;
    localparam int unsigned SLOT_W   = 4;

    localparam int unsigned I_MSB = 31;
    localparam int unsigned I_LSB = 16;
    localparam int unsigned Q_MSB = 15;
    localparam int unsigned Q_LSB = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_ACC   = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    // nat: the header landed where the slot counter would have wrapped anyway
    typedef struct packed {
        logic              mode;
        logic              hd;
        logic              nat;
        logic [SLOT_W-1:0] slot;
    } pow_tag_t;

    localparam int unsigned TAG_W = $bits(pow_tag_t);

    function automatic logic [SLOT_W-1:0] last_slot(input logic ant8, input int unsigned xnum);
        return ant8 ? SLOT_W'(xnum - 1) : SLOT_W'(3);
    endfunction

endpackage

// File: rtl/ul_pow_sq_sum.sv
// Two-stage I^2 + Q^2 pipeline; valid and sideband tag travel alongside.
module ul_pow_sq_sum
    import ul_pow_pkg::*;
(
    input  logic             clk,
    input  logic             asy_rst,
    input  logic             i_flush,
    input  logic             i_vld,
    input  logic [31:0]      i_data,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_vld,
    output logic [31:0]      o_sum,
    output logic [TAG_W-1:0] o_tag
);

    logic signed [31:0] w_i_ext;
    logic signed [31:0] w_q_ext;
    logic [31:0]        r_i2;
    logic [31:0]        r_q2;
    logic               r_sq_vld;
    logic [TAG_W-1:0]   r_sq_tag;
    logic               r_sum_vld;
    logic [31:0]        r_sum;
    logic [TAG_W-1:0]   r_sum_tag;

    assign w_i_ext = {{16{i_data[I_MSB]}}, i_data[I_MSB:I_LSB]};
    assign w_q_ext = {{16{i_data[Q_MSB]}}, i_data[Q_MSB:Q_LSB]};

    // Each square is at most 2^30, so the unsigned sum always fits in 32 bits
    always_ff @(posedge clk) begin
        if (!asy_rst) begin
            r_sq_vld  <= 1'b0;
            r_sum_vld <= 1'b0;
            r_i2      <= '0;
            r_q2      <= '0;
            r_sq_tag  <= '0;
            r_sum     <= '0;
            r_sum_tag <= '0;
        end else begin
            r_sq_vld  <= i_vld && !i_flush;
            r_sum_vld <= r_sq_vld && !i_flush;
            r_i2      <= w_i_ext * w_i_ext;
            r_q2      <= w_q_ext * w_q_ext;
            r_sq_tag  <= i_tag;
            r_sum     <= r_i2 + r_q2;
            r_sum_tag <= r_sq_tag;
        end
    end

    assign o_vld = r_sum_vld;
    assign o_sum = r_sum;
    assign o_tag = r_sum_tag;

endmodule

// File: rtl/ul_path_pow_meas_60m.sv
// Per-antenna mean power over 2^WIN_LOG2 TDM rounds, with header resync,
// back-to-back windows and 4/8-antenna mode.
module ul_path_pow_meas_60m
    import ul_pow_pkg::*;
#(
    parameter int unsigned XNUM     = XNUM_DEF,
    parameter int unsigned WIN_LOG2 = 10
) (
    input  logic        clk,
    input  logic        asy_rst,
    input  logic        i_fram_hd,
    input  logic        i_ant8_sel,
    input  logic [31:0] i_data,
    input  logic        i_data_valid,
    input  logic        i_meas_en,
    output logic [31:0] o_ant0_pow,
    output logic [31:0] o_ant1_pow,
    output logic [31:0] o_ant2_pow,
    output logic [31:0] o_ant3_pow,
    output logic [31:0] o_ant4_pow,
    output logic [31:0] o_ant5_pow,
    output logic [31:0] o_ant6_pow,
    output logic [31:0] o_ant7_pow,
    output logic        o_pow_vld,
    output logic        o_resync
);

    localparam int unsigned AW = 32 + WIN_LOG2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [SLOT_W-1:0]   r_slot_cnt;
    logic                r_mode;
    logic                w_last_prev;
    logic [SLOT_W-1:0]   w_slot_new;
    pow_tag_t            w_in_tag;
    logic                r_in_vld;
    logic [31:0]         r_in_data;
    logic [TAG_W-1:0]    r_in_tag;
    logic                w_sum_vld;
    logic [31:0]         w_sum;
    logic [TAG_W-1:0]    w_sum_tag;
    pow_tag_t            w_tag;
    logic                w_tag_last;
    logic                w_resync;
    logic                w_win_done;
    logic                w_start;
    logic [AW-1:0]       r_acc [XNUM];
    logic [AW-1:0]       w_accx [8];
    logic [WIN_LOG2-1:0] r_rcnt;
    logic                r_win_mode;
    logic                r_resync;
    logic                r_pow_vld;
    logic [31:0]         r_pow [8];

    // Slot tracking runs on the raw input stream regardless of FSM state
    assign w_last_prev = (r_slot_cnt == last_slot(r_mode, XNUM));
    assign w_slot_new  = (i_fram_hd || w_last_prev) ? '0 : r_slot_cnt + SLOT_W'(1);

    always_comb begin
        w_in_tag      = '0;
        w_in_tag.mode = i_fram_hd ? i_ant8_sel : r_mode;
        w_in_tag.hd   = i_fram_hd;
        w_in_tag.nat  = w_last_prev;
        w_in_tag.slot = w_slot_new;
    end

    always_ff @(posedge clk) begin
        if (!asy_rst) begin
            r_slot_cnt <= '0;
            r_mode     <= 1'b0;
            r_in_vld   <= 1'b0;
            r_in_data  <= '0;
            r_in_tag   <= '0;
        end else begin
            r_in_vld <= i_data_valid && i_meas_en;
            if (i_data_valid) begin
                r_slot_cnt <= w_slot_new;
                r_in_data  <= i_data;
                r_in_tag   <= w_in_tag;
                if (i_fram_hd) begin
                    r_mode <= i_ant8_sel;
                end
            end
        end
    end

    ul_pow_sq_sum u_sq_sum (
        .clk     (clk),
        .asy_rst (asy_rst),
        .i_flush (!i_meas_en),
        .i_vld   (r_in_vld),
        .i_data  (r_in_data),
        .i_tag   (r_in_tag),
        .o_vld   (w_sum_vld),
        .o_sum   (w_sum),
        .o_tag   (w_sum_tag)
    );

    assign w_tag      = pow_tag_t'(w_sum_tag);
    assign w_tag_last = (w_tag.slot == last_slot(w_tag.mode, XNUM));
    assign w_resync   = (r_state == ST_ACC) && w_sum_vld && w_tag.hd && !w_tag.nat;
    assign w_win_done = (r_state == ST_ACC) && w_sum_vld && w_tag_last && !w_resync
                        && (r_rcnt == '1);
    // A sample seeds a fresh window in ARM (header only) or in LATCH (next window's slot 0)
    assign w_start    = w_sum_vld && ((r_state == ST_LATCH) || w_tag.hd);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_ARM;
            ST_ARM:   if (w_sum_vld && w_tag.hd) w_state_nxt = ST_ACC;
            ST_ACC:   if (w_win_done) w_state_nxt = ST_LATCH;
            ST_LATCH: w_state_nxt = ST_ACC;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (!i_meas_en) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!asy_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!asy_rst) begin
            for (int unsigned k = 0; k < XNUM; k++) begin
                r_acc[k] <= '0;
            end
            r_rcnt     <= '0;
            r_win_mode <= 1'b0;
            r_resync   <= 1'b0;
        end else begin
            r_resync <= w_resync;
            case (r_state)
                ST_ACC: begin
                    if (w_sum_vld) begin
                        r_win_mode <= w_tag.mode;
                        if (w_resync) begin
                            for (int unsigned k = 0; k < XNUM; k++) begin
                                r_acc[k] <= (w_tag.slot == SLOT_W'(k)) ? {{WIN_LOG2{1'b0}}, w_sum} : '0;
                            end
                            r_rcnt <= '0;
                        end else begin
                            for (int unsigned k = 0; k < XNUM; k++) begin
                                if (w_tag.slot == SLOT_W'(k)) begin
                                    r_acc[k] <= r_acc[k] + {{WIN_LOG2{1'b0}}, w_sum};
                                end
                            end
                            if (w_tag_last) begin
                                r_rcnt <= r_rcnt + WIN_LOG2'(1);
                            end
                        end
                    end
                end
                ST_ARM, ST_LATCH: begin
                    for (int unsigned k = 0; k < XNUM; k++) begin
                        r_acc[k] <= (w_start && (w_tag.slot == SLOT_W'(k)))
                                    ? {{WIN_LOG2{1'b0}}, w_sum} : '0;
                    end
                    r_rcnt <= '0;
                    if (w_start) begin
                        r_win_mode <= w_tag.mode;
                    end
                end
                default: begin
                    for (int unsigned k = 0; k < XNUM; k++) begin
                        r_acc[k] <= '0;
                    end
                    r_rcnt <= '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_accx
        if (g < XNUM) begin : g_on
            assign w_accx[g] = r_acc[g];
        end else begin : g_off
            assign w_accx[g] = '0;
        end
    end

    // LATCH reads the accumulators before the same edge clears them
    always_ff @(posedge clk) begin
        if (!asy_rst) begin
            r_pow_vld <= 1'b0;
            for (int unsigned k = 0; k < 8; k++) begin
                r_pow[k] <= '0;
            end
        end else begin
            r_pow_vld <= (r_state == ST_LATCH);
            if (r_state == ST_LATCH) begin
                for (int unsigned k = 0; k < 8; k++) begin
                    r_pow[k] <= (k < 4 || r_win_mode) ? w_accx[k][AW-1:WIN_LOG2] : '0;
                end
            end
        end
    end

    assign o_ant0_pow = r_pow[0];
    assign o_ant1_pow = r_pow[1];
    assign o_ant2_pow = r_pow[2];
    assign o_ant3_pow = r_pow[3];
    assign o_ant4_pow = r_pow[4];
    assign o_ant5_pow = r_pow[5];
    assign o_ant6_pow = r_pow[6];
    assign o_ant7_pow = r_pow[7];
    assign o_pow_vld  = r_pow_vld;
    assign o_resync   = r_resync;

endmodule

// File: tb/tb_ul_path_pow_meas_60m.sv
// Directed bench for ul_path_pow_meas_60m with a 4-round window (WIN_LOG2=2).
module tb_ul_path_pow_meas_60m;

    logic        clk = 1'b0;
    logic        asy_rst;
    logic        i_fram_hd;
    logic        i_ant8_sel;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic        i_meas_en;
    logic [31:0] o_pow [8];
    logic        o_pow_vld;
    logic        o_resync;

    int cyc      = 0;
    int last_cyc = 0;
    int vld_cnt  = 0;
    int vld_cyc  = 0;
    int rs_cnt   = 0;
    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct packed {
        logic             ant8;
        logic             gap;
        logic             half;
        logic [7:0][15:0] iv;
        logic [7:0][15:0] qv;
        logic [7:0][31:0] exp;
    } vec_t;

    vec_t vecs [5];

    ul_path_pow_meas_60m #(.XNUM(8), .WIN_LOG2(2)) dut (
        .clk          (clk),
        .asy_rst      (asy_rst),
        .i_fram_hd    (i_fram_hd),
        .i_ant8_sel   (i_ant8_sel),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_meas_en    (i_meas_en),
        .o_ant0_pow   (o_pow[0]),
        .o_ant1_pow   (o_pow[1]),
        .o_ant2_pow   (o_pow[2]),
        .o_ant3_pow   (o_pow[3]),
        .o_ant4_pow   (o_pow[4]),
        .o_ant5_pow   (o_pow[5]),
        .o_ant6_pow   (o_pow[6]),
        .o_ant7_pow   (o_pow[7]),
        .o_pow_vld    (o_pow_vld),
        .o_resync     (o_resync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_pow_vld === 1'b1) begin
            vld_cnt = vld_cnt + 1;
            vld_cyc = cyc;
        end
        if (o_resync === 1'b1) begin
            rs_cnt = rs_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt = pass_cnt + 1;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic hd, input logic ant);
        i_data       = d;
        i_fram_hd    = hd;
        i_ant8_sel   = ant;
        i_data_valid = 1'b1;
        @(posedge clk);
        #1;
        last_cyc = cyc;
    endtask

    // Bubbles carry garbage data and a header flag that must both be ignored
    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            i_data_valid = 1'b0;
            i_data       = 32'h7FFF_7FFF;
            i_fram_hd    = 1'b1;
            i_ant8_sel   = ~i_ant8_sel;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic restart();
        i_meas_en = 1'b0;
        idle(3);
        i_meas_en = 1'b1;
    endtask

    task automatic chk_outs(input string name, input logic [31:0] exp);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_ant%0d", name, k), o_pow[k], exp);
        end
    endtask

    initial begin
        int b_v;
        int b_r;
        int nsl;
        logic [31:0] d;

        for (int k = 0; k < 8; k++) begin
            vecs[0].iv[k]  = 16'h0100;
            vecs[0].qv[k]  = 16'h0100;
            vecs[0].exp[k] = 32'h0002_0000;
            vecs[1].iv[k]  = 16'h0000;
            vecs[1].qv[k]  = 16'h0000;
            vecs[1].exp[k] = 32'h0000_0000;
            vecs[2].iv[k]  = 16'h8000;
            vecs[2].qv[k]  = 16'h8000;
            vecs[2].exp[k] = 32'h8000_0000;
            vecs[3].iv[k]  = 16'h0010 * 16'(k + 1);
            vecs[3].qv[k]  = 16'hFFE0;
            vecs[4].iv[k]  = 16'h0003;
            vecs[4].qv[k]  = 16'(k);
        end
        vecs[0].ant8 = 1'b1; vecs[0].gap = 1'b0; vecs[0].half = 1'b0;
        vecs[1].ant8 = 1'b0; vecs[1].gap = 1'b0; vecs[1].half = 1'b0;
        vecs[2].ant8 = 1'b1; vecs[2].gap = 1'b0; vecs[2].half = 1'b0;
        vecs[3].ant8 = 1'b1; vecs[3].gap = 1'b1; vecs[3].half = 1'b0;
        vecs[4].ant8 = 1'b1; vecs[4].gap = 1'b0; vecs[4].half = 1'b1;
        vecs[1].iv[1] = 16'h0100; vecs[1].exp[1] = 32'h0001_0000;
        vecs[1].iv[2] = 16'h0200; vecs[1].exp[2] = 32'h0004_0000;
        vecs[1].iv[3] = 16'h0300; vecs[1].exp[3] = 32'h0009_0000;
        vecs[3].exp[0] = 32'h0000_0500; vecs[3].exp[1] = 32'h0000_0800;
        vecs[3].exp[2] = 32'h0000_0D00; vecs[3].exp[3] = 32'h0000_1400;
        vecs[3].exp[4] = 32'h0000_1D00; vecs[3].exp[5] = 32'h0000_2800;
        vecs[3].exp[6] = 32'h0000_3500; vecs[3].exp[7] = 32'h0000_4400;
        vecs[4].exp[0] = 32'd4;  vecs[4].exp[1] = 32'd5;
        vecs[4].exp[2] = 32'd6;  vecs[4].exp[3] = 32'd9;
        vecs[4].exp[4] = 32'd12; vecs[4].exp[5] = 32'd17;
        vecs[4].exp[6] = 32'd22; vecs[4].exp[7] = 32'd29;

        asy_rst      = 1'b0;
        i_meas_en    = 1'b0;
        i_ant8_sel   = 1'b0;
        i_fram_hd    = 1'b0;
        i_data       = '0;
        i_data_valid = 1'b0;
        idle(4);
        chk_outs("reset", 32'h0);
        chk("reset_pow_vld", {31'b0, o_pow_vld}, 32'h0);
        chk("reset_resync", {31'b0, o_resync}, 32'h0);
        asy_rst = 1'b1;
        idle(2);

        for (int v = 0; v < 5; v++) begin
            restart();
            b_v = vld_cnt;
            nsl = vecs[v].ant8 ? 8 : 4;
            for (int r = 0; r < 4; r++) begin
                for (int s = 0; s < nsl; s++) begin
                    d = (vecs[v].half && r[0]) ? 32'h0 : {vecs[v].iv[s], vecs[v].qv[s]};
                    if (r == 0 && s == 0) send(d, 1'b1, vecs[v].ant8);
                    else                  send(d, 1'b0, ~vecs[v].ant8);
                    if (vecs[v].gap) idle(1);
                end
            end
            b_r = last_cyc;
            idle(12);
            chk($sformatf("vec%0d_vld_count", v), 32'(vld_cnt - b_v), 32'd1);
            chk($sformatf("vec%0d_latency", v), 32'(vld_cyc - b_r), 32'd4);
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("vec%0d_ant%0d", v, k), o_pow[k], vecs[v].exp[k]);
            end
        end

        // Header arrives at slot 5 of the third round: window restarts there
        restart();
        b_v = vld_cnt;
        b_r = rs_cnt;
        for (int n = 0; n < 21; n++) begin
            send({16'h0100, 16'h0100}, n == 0, 1'b1);
        end
        for (int n = 0; n < 32; n++) begin
            send({16'h0200, 16'h0000}, n == 0, 1'b1);
            if (n == 30) begin
                chk("resync_no_early_vld", 32'(vld_cnt - b_v), 32'd0);
            end
        end
        b_v = b_v + 0;
        idle(12);
        chk("resync_pulses", 32'(rs_cnt - b_r), 32'd1);
        chk("resync_vld_count", 32'(vld_cnt - b_v), 32'd1);
        chk("resync_latency", 32'(vld_cyc - last_cyc), 32'd4);
        chk_outs("resync", 32'h0004_0000);

        // Enable dropped mid-window: partial window discarded, outputs hold
        restart();
        b_v = vld_cnt;
        for (int n = 0; n < 16; n++) begin
            send({16'h0300, 16'h0000}, n == 0, 1'b1);
        end
        i_meas_en = 1'b0;
        idle(1);
        i_meas_en = 1'b1;
        for (int n = 0; n < 16; n++) begin
            send({16'h0300, 16'h0000}, 1'b0, 1'b1);
        end
        idle(12);
        chk("en_drop_no_vld", 32'(vld_cnt - b_v), 32'd0);
        chk_outs("en_drop_hold", 32'h0004_0000);

        // Reset mid-window: outputs cleared, no result for the broken window
        restart();
        b_v = vld_cnt;
        for (int n = 0; n < 16; n++) begin
            send({16'h0300, 16'h0000}, n == 0, 1'b1);
        end
        asy_rst = 1'b0;
        idle(1);
        asy_rst = 1'b1;
        chk_outs("rst_drop", 32'h0);
        for (int n = 0; n < 16; n++) begin
            send({16'h0300, 16'h0000}, 1'b0, 1'b1);
        end
        idle(12);
        chk("rst_drop_no_vld", 32'(vld_cnt - b_v), 32'd0);
        chk_outs("rst_drop_after", 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
